// File: rtl/fp16_add_tree_acc.sv
// -----------------------------------------------------------------------------
// fp16_add_tree_acc
//   Fully pipelined fp16 reduction tree with optional multi-beat accumulation.
//   Each accepted beat carries NUM_IN fp16 operands. A balanced binary tree of
//   fp16_add cells reduces them to one value. A final fp16_add folds that value
//   into a running accumulator until a beat marked in_last closes the group.
//
//   Ports
//     clk          clock
//     rst_n        asynchronous active-low reset
//     in_valid     beat valid
//     in_ready     beat accepted when in_valid & in_ready
//     in_last      final beat of an accumulation group
//     operands_i   packed operands, operand k at [k*WIDTH +: WIDTH]
//     out_valid    result valid
//     out_ready    downstream accept
//     add_reg_o    registered fp16 group sum
//     out_beats_o  beats in the emitted group (saturating)
//
//   Latency from an accepted last beat to out_valid, with no stalls, is
//   2 + ceil(LEVELS/PIPE_EVERY) cycles. All stages share one enable, so a
//   stalled output freezes the whole pipe and bubbles are kept.
// -----------------------------------------------------------------------------

// Combinational fp16 adder (IEEE binary16, round to nearest even).
// Subnormals are supported. Any NaN input, or the sum of opposite infinities,
// gives the canonical quiet NaN 0x7E00. An exact zero from operands of
// opposite sign is +0.
module fp16_add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, sub, sticky, rnd;
  logic [15:0] hi, lo;
  logic [4:0]  e_hi, e_lo, dexp, sh, e_enc;
  logic [13:0] x_hi, x_lo, x_sh, m;
  logic [14:0] r, packed_v;
  logic [3:0]  lz;
  logic [5:0]  e_norm;

  always_comb begin
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);

    // Order by magnitude so the subtraction never goes negative.
    swap = b[14:0] > a[14:0];
    hi   = swap ? b : a;
    lo   = swap ? a : b;

    // Subnormals use exponent 1 with no hidden bit.
    e_hi = (hi[14:10] == 5'd0) ? 5'd1 : hi[14:10];
    e_lo = (lo[14:10] == 5'd0) ? 5'd1 : lo[14:10];
    // 11-bit significand followed by guard, round and sticky positions.
    x_hi = {(hi[14:10] != 5'd0), hi[9:0], 3'b000};
    x_lo = {(lo[14:10] != 5'd0), lo[9:0], 3'b000};

    // Align the smaller operand; everything shifted out collapses into sticky.
    dexp = e_hi - e_lo;
    if (dexp >= 5'd14) begin
      x_sh   = 14'd0;
      sticky = |x_lo;
    end else begin
      x_sh   = x_lo >> dexp;
      sticky = |(x_lo & ~(14'h3fff << dexp));
    end
    x_sh[0] = x_sh[0] | sticky;

    sub = hi[15] ^ lo[15];
    r   = sub ? ({1'b0, x_hi} - {1'b0, x_sh}) : ({1'b0, x_hi} + {1'b0, x_sh});

    // Position of the leading one in r[13:0] (14 when r[13:0] is zero).
    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (r[i]) lz = 4'(13 - i);
    end

    sh = 5'd0;
    if (r[14]) begin
      // Carry out: shift right one place, keeping the lost bit as sticky.
      m      = r[14:1] | {13'd0, r[0]};
      e_norm = {1'b0, e_hi} + 6'd1;
    end else begin
      // Left shift limited so the exponent never drops below 1; anything
      // still unnormalised afterwards is a subnormal result.
      sh     = ({1'b0, lz} < (e_hi - 5'd1)) ? {1'b0, lz} : (e_hi - 5'd1);
      m      = r[13:0] << sh;
      e_norm = {1'b0, e_hi} - {1'b0, sh};
    end

    e_enc = m[13] ? e_norm[4:0] : 5'd0;
    rnd   = m[2] & (m[3] | m[1] | m[0]);
    // Rounding into the concatenated exponent/mantissa lets a mantissa carry
    // bump the exponent, promote a subnormal to normal, or overflow to inf.
    packed_v = {e_enc, m[12:3]} + {14'd0, rnd};

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      y = 16'h7e00;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (r == 15'd0) begin
      y = {a[15] & b[15], 15'd0};
    end else if (e_norm >= 6'd31) begin
      y = {hi[15], 15'h7c00};
    end else begin
      y = {hi[15], packed_v};
    end
  end
endmodule

module fp16_add_tree_acc #(
  parameter int NUM_IN     = 8,
  parameter int PIPE_EVERY = 1,
  parameter int CNT_W      = 8,
  parameter int WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [NUM_IN*WIDTH-1:0] operands_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        add_reg_o,
  output logic [CNT_W-1:0]        out_beats_o
);
  localparam int LEVELS = $clog2(NUM_IN);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Level 0 is the input register; level gl holds NUM_IN>>gl partial sums.
  // A level is registered at level 0, every PIPE_EVERY levels, and at the top.
  for (genvar gl = 0; gl <= LEVELS; gl++) begin : g_lvl
    localparam int CNT = NUM_IN >> gl;
    localparam bit REG = (gl == 0) || ((gl % PIPE_EVERY) == 0) || (gl == LEVELS);

    logic [WIDTH-1:0] node [CNT];
    logic             vld;
    logic             lst;
    logic             vld_d;
    logic             lst_d;

    for (genvar gi = 0; gi < CNT; gi++) begin : g_node
      logic [WIDTH-1:0] d;
      if (gl == 0) begin : g_src
        assign d = operands_i[gi*WIDTH +: WIDTH];
      end else begin : g_add
        fp16_add u_add (
          .a (g_lvl[gl-1].node[2*gi]),
          .b (g_lvl[gl-1].node[2*gi+1]),
          .y (d)
        );
      end
      if (REG) begin : g_reg
        logic [WIDTH-1:0] d_reg;
        // Data registers carry no reset; valid qualifies them.
        always_ff @(posedge clk) begin
          if (en) d_reg <= d;
        end
        assign node[gi] = d_reg;
      end else begin : g_wire
        assign node[gi] = d;
      end
    end

    if (gl == 0) begin : g_csrc
      assign vld_d = in_valid;
      assign lst_d = in_last;
    end else begin : g_cprev
      assign vld_d = g_lvl[gl-1].vld;
      assign lst_d = g_lvl[gl-1].lst;
    end

    if (REG) begin : g_creg
      logic vld_reg, lst_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg <= 1'b0;
          lst_reg <= 1'b0;
        end else if (en) begin
          vld_reg <= vld_d;
          lst_reg <= lst_d;
        end
      end
      assign vld = vld_reg;
      assign lst = lst_reg;
    end else begin : g_cwire
      assign vld = vld_d;
      assign lst = lst_d;
    end
  end

  // Accumulate stage.
  logic [WIDTH-1:0] tree_sum, acc_reg, acc_sum;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;
  logic             tree_vld, tree_lst;

  assign tree_sum = g_lvl[LEVELS].node[0];
  assign tree_vld = g_lvl[LEVELS].vld;
  assign tree_lst = g_lvl[LEVELS].lst;
  assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

  fp16_add u_acc_add (
    .a (acc_reg),
    .b (tree_sum),
    .y (acc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      add_reg_o   <= '0;
      out_beats_o <= '0;
      out_valid   <= 1'b0;
    end else if (en) begin
      if (tree_vld) begin
        if (tree_lst) begin
          add_reg_o   <= acc_sum;
          out_beats_o <= cnt_inc;
          out_valid   <= 1'b1;
          acc_reg     <= '0;
          cnt_reg     <= '0;
        end else begin
          acc_reg   <= acc_sum;
          cnt_reg   <= cnt_inc;
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp16_add_tree_acc.sv
// -----------------------------------------------------------------------------
// tb_fp16_add_tree_acc
//   Drives four instances from one operand bus: default, PIPE_EVERY=2,
//   PIPE_EVERY=3 and CNT_W=2. Expected results are hand-computed constants
//   queued per instance when the closing beat is accepted and compared when
//   the instance presents out_valid & out_ready.
// -----------------------------------------------------------------------------
module tb_fp16_add_tree_acc;
  localparam int ND = 4;

  typedef struct {
    logic [127:0] ops;
    int           nb;
    logic [15:0]  sum;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    int          nb;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           in_valid_a, in_valid_x, in_last, out_ready_a;
  logic [127:0]   operands;
  logic [ND-1:0]  in_ready, out_valid, ordy;
  logic [ND-1:0][15:0] add_reg;
  logic [ND-1:0][7:0]  beats;
  logic [7:0]     beats_d0, beats_d1, beats_d2;
  logic [1:0]     beats_c2;

  assign ordy  = {3'b111, out_ready_a};
  assign beats = {{6'd0, beats_c2}, beats_d2, beats_d1, beats_d0};

  fp16_add_tree_acc u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready[0]),
    .in_last(in_last), .operands_i(operands), .out_valid(out_valid[0]),
    .out_ready(out_ready_a), .add_reg_o(add_reg[0]), .out_beats_o(beats_d0)
  );
  fp16_add_tree_acc #(.PIPE_EVERY(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready[1]),
    .in_last(in_last), .operands_i(operands), .out_valid(out_valid[1]),
    .out_ready(1'b1), .add_reg_o(add_reg[1]), .out_beats_o(beats_d1)
  );
  fp16_add_tree_acc #(.PIPE_EVERY(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready[2]),
    .in_last(in_last), .operands_i(operands), .out_valid(out_valid[2]),
    .out_ready(1'b1), .add_reg_o(add_reg[2]), .out_beats_o(beats_d2)
  );
  fp16_add_tree_acc #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready[3]),
    .in_last(in_last), .operands_i(operands), .out_valid(out_valid[3]),
    .out_ready(1'b1), .add_reg_o(add_reg[3]), .out_beats_o(beats_c2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sbq [ND][$];
  logic hold_prev = 1'b0;
  logic [15:0] hold_val = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    case (d)
      1:       return 4;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int maxb_of(input int d);
    return (d == 3) ? 3 : 255;
  endfunction

  function automatic logic [127:0] rep8(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (out_valid[d] && ordy[d]) begin
          if (sbq[d].size() == 0) begin
            chk($sformatf("spurious_out_dut%0d", d), int'(out_valid[d]), 0);
          end else begin
            exp_t e;
            int   eb;
            e  = sbq[d].pop_front();
            eb = (e.nb > maxb_of(d)) ? maxb_of(d) : e.nb;
            $display("out dut%0d cyc=%0d sum=%h beats=%0d exp_sum=%h exp_beats=%0d",
                     d, cyc, add_reg[d], beats[d], e.sum, eb);
            chk($sformatf("sum_dut%0d", d), int'(add_reg[d]), int'(e.sum));
            chk($sformatf("beats_dut%0d", d), int'(beats[d]), eb);
            if (e.chk_lat) chk($sformatf("latency_dut%0d", d), cyc - e.acc_cyc, lat_of(d));
          end
        end
      end
      if (hold_prev) begin
        chk("hold_valid", int'(out_valid[0]), 1);
        chk("hold_data", int'(add_reg[0]), int'(hold_val));
      end
      if (!out_ready_a) chk("in_ready_stall", int'(in_ready[0]), int'(!out_valid[0]));
      hold_prev = out_valid[0] && !out_ready_a;
      hold_val  = add_reg[0];
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Drive one beat and wait for acceptance; queue expectations on the last beat.
  task automatic send(input logic [127:0] ops, input bit last, input bit all,
                      input logic [15:0] sum, input int nb, input bit lat_ok);
    int   waited;
    exp_t e;
    waited = 0;
    @(posedge clk);
    #1;
    operands   = ops;
    in_last    = last;
    in_valid_a = 1'b1;
    in_valid_x = all;
    @(negedge clk);
    while (!in_ready[0] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[0]) chk("accept_timeout", int'(in_ready[0]), 1);
    if (last) begin
      e.sum = sum; e.nb = nb; e.acc_cyc = cyc; e.chk_lat = lat_ok;
      for (int d = 0; d < ND; d++) begin
        if (d == 0 || all) sbq[d].push_back(e);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_x = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic drain();
    int n, pend;
    n    = 0;
    pend = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
    while (pend != 0 && n < 300) begin
      @(negedge clk);
      n++;
      pend = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
    end
    chk("drain_pending", pend, 0);
  endtask

  vec_t        tbl [13];
  logic [15:0] st_in  [10];
  logic [15:0] st_exp [10];

  initial begin
    tbl[0]  = '{rep8(16'h3C00), 1, 16'h4800};
    tbl[1]  = '{{{4{16'hBC00}}, {4{16'h3C00}}}, 1, 16'h0000};
    tbl[2]  = '{rep8(16'h4000), 1, 16'h4C00};
    tbl[3]  = '{rep8(16'h3800), 1, 16'h4400};
    tbl[4]  = '{{16'h4800, 16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 1, 16'h5080};
    tbl[5]  = '{{{7{16'h3C00}}, 16'h7C00}, 1, 16'h7C00};
    tbl[6]  = '{rep8(16'hB400), 1, 16'hC000};
    tbl[7]  = '{{{6{16'h0000}}, 16'h4200, 16'h6800}, 1, 16'h6802};
    tbl[8]  = '{rep8(16'h0001), 1, 16'h0008};
    tbl[9]  = '{rep8(16'h3C00), 3, 16'h4E00};
    tbl[10] = '{{16'h4800, 16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 2, 16'h5480};
    tbl[11] = '{{{6{16'h0000}}, 16'hFC00, 16'h7C00}, 1, 16'h7E00};
    tbl[12] = '{rep8(16'h3C00), 5, 16'h5100};

    st_in  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
               16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900};
    st_exp = '{16'h4000, 16'h4400, 16'h4600, 16'h4800, 16'h4900,
               16'h4A00, 16'h4B00, 16'h4C00, 16'h4C80, 16'h4D00};

    rst_n = 1'b0; in_valid_a = 1'b0; in_valid_x = 1'b0; in_last = 1'b0;
    operands = '0; out_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_valid_dut%0d", d), int'(out_valid[d]), 0);
      chk($sformatf("rst_sum_dut%0d", d), int'(add_reg[d]), 0);
      chk($sformatf("rst_beats_dut%0d", d), int'(beats[d]), 0);
      chk($sformatf("rst_ready_dut%0d", d), int'(in_ready[d]), 1);
    end
    rst_n = 1'b1;

    // Table vectors, all instances, back to back.
    for (int t = 0; t < 13; t++) begin
      for (int b = 0; b < tbl[t].nb; b++) begin
        send(tbl[t].ops, (b == tbl[t].nb - 1), 1'b1, tbl[t].sum, tbl[t].nb, 1'b1);
      end
    end
    idle();
    drain();

    // Reset in the middle of an unfinished group.
    send(rep8(16'h4000), 1'b0, 1'b1, 16'h0000, 0, 1'b0);
    send(rep8(16'h4000), 1'b0, 1'b1, 16'h0000, 0, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("midrst_valid_dut%0d", d), int'(out_valid[d]), 0);
      chk($sformatf("midrst_sum_dut%0d", d), int'(add_reg[d]), 0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    send(rep8(16'h4000), 1'b1, 1'b1, 16'h4C00, 1, 1'b1);
    idle();
    drain();

    // Back-to-back singles on the default instance with a 4-cycle stall.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send({st_in[i], {6{16'h0000}}, st_in[i]}, 1'b1, 1'b0, st_exp[i], 1, 1'b0);
        end
        idle();
      end
      begin
        repeat (8) @(posedge clk);
        #2 out_ready_a = 1'b0;
        repeat (4) @(posedge clk);
        #2 out_ready_a = 1'b1;
      end
    join
    drain();

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp16_add_tree_acc.md
Name: fp16_add_tree_acc

Overview:
- Parametrised, fully pipelined fp16 reduction tree. Sums NUM_IN fp16 operands per beat using a balanced binary tree of the existing combinational two-input fp16 adder cell.
- Optionally accumulates tree sums across a multi-beat group delimited by in_last.
- Successor to the fixed 8-input, 2-register adder tree in the VPE datapath. Adds configurable width/depth, pipeline-register placement, valid/ready backpressure, group accumulation and a beat counter.

Parameters:
- NUM_IN, 8, operands per beat; power of two, >= 2; LEVELS = log2(NUM_IN).
- PIPE_EVERY, 1, insert a pipeline register after every PIPE_EVERY tree levels; a register always follows the last level; range 1..LEVELS.
- CNT_W, 8, width of the beat counter.
- WIDTH, 16, fp16 word width; fixed (localparam-style, not overridable in practice).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_last  in  1  marks the final beat of an accumulation group; tie to 1 for per-beat sums.
- operands_i  in  NUM_IN*WIDTH  packed fp16 operands, operand k at [k*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- add_reg_o  out  WIDTH  fp16 group sum, registered.
- out_beats_o  out  CNT_W  number of beats in the emitted group, saturating at 2^CNT_W-1.

Behaviour:
- Reset (async assert, sync-safe deassert): all valid bits 0; add_reg_o = 0x0000; out_beats_o = 0; accumulator = +0 (0x0000); beat counter = 0. Pipeline data registers need not be reset.
- Global enable: en = ~out_valid | out_ready. in_ready = en, combinational from out_valid and out_ready only; no combinational path from in_valid.
- When en = 0, every stage holds, including valids, data, accumulator and counter. Bubbles are not collapsed.
- Stage 0: input register captures operands_i, in_last and valid = in_valid on en.
- Tree: level j pairs adjacent results (2i, 2i+1). Arithmetic, rounding and special values are those of the leaf adder cell. The tree adds no extra normalisation.
- Tree registers sit after levels PIPE_EVERY, 2*PIPE_EVERY, ... and after level LEVELS. Each register carries valid and last.
- Accumulate stage, on en with tree-output valid = 1:
  - sum = acc + tree, computed by one further leaf adder.
  - If last: add_reg_o <= sum; out_valid <= 1; out_beats_o <= cnt+1 (saturating); acc <= 0x0000; cnt <= 0.
  - Else: acc <= sum; cnt <= cnt+1 (saturating); out_valid <= 0.
- Accumulate stage, on en with tree-output valid = 0: out_valid <= 0; acc and cnt hold; add_reg_o holds its last value.
- Latency from accepted beat carrying last to out_valid, with no stalls: LAT = 2 + ceil(LEVELS/PIPE_EVERY) cycles. Default configuration gives 5.
- Throughput: one beat per cycle while out_ready = 1.
- Group of one beat (in_last = 1 on the first beat): output equals tree sum + (+0).
- Counter saturation: cnt stops at all-ones; the summation itself is unaffected.
- Reset mid-group: the partial accumulator and all in-flight beats are discarded; the next group starts from +0.
- in_last asserted while in_valid = 0 is ignored.

Test Plan:
- Default parameters, one beat of eight 1.0 (0x3C00), in_last = 1, out_ready = 1 -> out_valid exactly 5 cycles after acceptance; add_reg_o = 0x4800 (8.0); out_beats_o = 1.
- Group of 3 beats, each eight 0x3C00, last on the third -> a single out_valid pulse; add_reg_o = 0x4E00 (24.0); out_beats_o = 3; no out_valid on beats 1-2.
- Operands {1.0 x4, -1.0 (0xBC00) x4}, last = 1 -> add_reg_o = 0x0000. Sweep PIPE_EVERY = 1, 2, 3 with NUM_IN = 8 -> latency 5, 4, 3 respectively, identical data.
- Back-to-back 10 single-beat groups with out_ready low for 4 cycles mid-stream -> in_ready low during those cycles; outputs held stable; no loss or duplication; results in order; add_reg_o stable while out_valid & ~out_ready.
- Assert rst_n low for 1 cycle after 2 beats of an unfinished group -> out_valid = 0 and add_reg_o = 0 immediately. Then a new 1-beat group of eight 2.0 (0x4000) -> add_reg_o = 0x4C00 (16.0); out_beats_o = 1.
- CNT_W = 2, 5-beat group of eight 0x3C00 -> add_reg_o = 0x5100 (40.0); out_beats_o = 3 (saturated).
